// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 line driver: shifts one upper/lower row pair per colour bit plane, latches it, then
// lights it for a binary-weighted time (BCM). Latency: accept to line_done is
// CH_BITS*(2*NUM_COLS+1) + BASE_OE_CYCLES*(2^CH_BITS-1) cycles.
// Backpressure: tready is high only in IDLE; a held tvalid is taken on the line_done cycle.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-low reset
//   line_data/line_addr row pair ([0] upper, [1] lower) and row-pair address, valid/ready with tvalid/tready
//   blank_in            forces the LEDs dark without changing any timing
//   rgb0/rgb1           upper/lower {R,G,B} bit of the current plane
//   led_clk/led_latch   panel shift clock and latch
//   led_oe_n            panel output enable, 0 = lit
//   addr_out            panel row address, changes only while dark
//   line_done           one-cycle pulse when the last plane has been displayed
module hub75_bcm_scan_driver #(
  parameter int NUM_COLS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int RGB_RES        = 9,
  parameter int BASE_OE_CYCLES = 4
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]      line_data,
  input  logic [$clog2(SCAN_RATE)-1:0]               line_addr,
  input  logic                                       tvalid,
  output logic                                       tready,
  input  logic                                       blank_in,
  output logic [2:0]                                 rgb0,
  output logic [2:0]                                 rgb1,
  output logic                                       led_clk,
  output logic                                       led_latch,
  output logic                                       led_oe_n,
  output logic [$clog2(SCAN_RATE)-1:0]               addr_out,
  output logic                                       line_done
);

  localparam int CH_BITS = RGB_RES / 3;
  localparam int AW      = $clog2(SCAN_RATE);
  localparam int PIX_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int PL_W    = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
  localparam int CNT_W   = $clog2(BASE_OE_CYCLES << CH_BITS);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_COLS - 1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(CH_BITS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_LATCH   = 2'd2;
  localparam logic [1:0] ST_DISPLAY = 2'd3;

  logic [1:0]                              state_q, state_d;
  logic                                    phase_q, phase_d;
  logic [PIX_W-1:0]                        pix_q, pix_d;
  logic [PL_W-1:0]                         plane_q, plane_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]   data_q, data_d;
  logic [AW-1:0]                           addr_cap_q, addr_cap_d;
  logic [AW-1:0]                           addr_q, addr_d;
  logic [2:0]                              rgb0_q, rgb0_d;
  logic [2:0]                              rgb1_q, rgb1_d;
  logic                                    done_q, done_d;

  // Bit 'pl' of each channel of a packed {R,G,B} pixel.
  function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                            input logic [PL_W-1:0]    pl);
    logic [CH_BITS-1:0] r, g, b;
    r = px[RGB_RES-1 -: CH_BITS];
    g = px[2*CH_BITS-1 -: CH_BITS];
    b = px[CH_BITS-1:0];
    return {r[pl], g[pl], b[pl]};
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pix_d      = pix_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    addr_cap_d = addr_cap_q;
    addr_d     = addr_q;
    rgb0_d     = rgb0_q;
    rgb1_d     = rgb1_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tvalid) begin
          data_d     = line_data;
          addr_cap_d = line_addr;
          plane_d    = '0;
          pix_d      = PIX_LAST;
          phase_d    = 1'b0;
          state_d    = ST_SHIFT;
          // First pixel is taken straight from the input so rgb is valid on the first SHIFT cycle.
          rgb0_d     = plane_bits(line_data[0][PIX_LAST], '0);
          rgb1_d     = plane_bits(line_data[1][PIX_LAST], '0);
        end
      end

      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (pix_q == '0) begin
            state_d = ST_LATCH;
            rgb0_d  = 3'b000;
            rgb1_d  = 3'b000;
            // The row address moves only once per line, on the first latch, while still dark.
            if (plane_q == '0) begin
              addr_d = addr_cap_q;
            end
          end else begin
            pix_d  = pix_q - 1'b1;
            rgb0_d = plane_bits(data_q[0][pix_q - 1'b1], plane_q);
            rgb1_d = plane_bits(data_q[1][pix_q - 1'b1], plane_q);
          end
        end
      end

      ST_LATCH: begin
        state_d = ST_DISPLAY;
        cnt_d   = CNT_W'(BASE_OE_CYCLES << plane_q);
      end

      ST_DISPLAY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (plane_q == PL_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
            pix_d   = PIX_LAST;
            phase_d = 1'b0;
            state_d = ST_SHIFT;
            rgb0_d  = plane_bits(data_q[0][PIX_LAST], plane_q + 1'b1);
            rgb1_d  = plane_bits(data_q[1][PIX_LAST], plane_q + 1'b1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      pix_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rgb0_q  <= 3'b000;
      rgb1_q  <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pix_q   <= pix_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      done_q  <= done_d;
    end
  end

  // Line storage is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk_in) begin
    data_q     <= data_d;
    addr_cap_q <= addr_cap_d;
  end

  assign tready    = (state_q == ST_IDLE);
  assign led_clk   = (state_q == ST_SHIFT) && phase_q;
  assign led_latch = (state_q == ST_LATCH);
  // blank_in gates the enable directly so it never alters the window length.
  assign led_oe_n  = !((state_q == ST_DISPLAY) && !blank_in);
  assign rgb0      = rgb0_q;
  assign rgb1      = rgb1_q;
  assign addr_out  = addr_q;
  assign line_done = done_q;

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
module tb_hub75_bcm_scan_driver;
  localparam int NUM_COLS = 4;
  localparam int SCAN_RATE = 32;
  localparam int RGB_RES = 9;
  localparam int BASE = 2;
  localparam int LINE_CYC = 41;

  typedef logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] line_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  line_t       line_data = '0;
  logic [4:0]  line_addr = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        blank_in = 1'b0;
  logic [2:0]  rgb0, rgb1;
  logic        led_clk, led_latch, led_oe_n;
  logic [4:0]  addr_out;
  logic        line_done;

  hub75_bcm_scan_driver #(
    .NUM_COLS(NUM_COLS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES), .BASE_OE_CYCLES(BASE)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .line_data(line_data), .line_addr(line_addr),
    .tvalid(tvalid), .tready(tready), .blank_in(blank_in), .rgb0(rgb0), .rgb1(rgb1),
    .led_clk(led_clk), .led_latch(led_latch), .led_oe_n(led_oe_n), .addr_out(addr_out),
    .line_done(line_done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass = 0;

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  logic [5:0] edge_q[$];
  int         latch_addr_q[$];
  int         oe_q[$];
  int         done_q[$];
  int         acc_q[$];
  int         unstable = 0;
  int         addr_viol = 0;
  int         lit = 0;
  int         run = 0;
  logic       prev_clk = 1'b0;
  logic [5:0] prev_rgb = '0;
  logic [4:0] prev_addr = '0;

  always @(negedge clk_in) begin
    if (led_clk && !prev_clk) begin
      edge_q.push_back({rgb0, rgb1});
      if ({rgb0, rgb1} !== prev_rgb) unstable++;
    end
    if (led_latch) latch_addr_q.push_back(int'(addr_out));
    if (!led_oe_n) begin
      run++;
      lit++;
      if (addr_out !== prev_addr) addr_viol++;
    end else if (run > 0) begin
      oe_q.push_back(run);
      run = 0;
    end
    if (line_done) done_q.push_back(cyc);
    // Accept happens on the next rising edge.
    if (rst_in && tvalid && tready) acc_q.push_back(cyc + 1);
    prev_clk  = led_clk;
    prev_rgb  = {rgb0, rgb1};
    prev_addr = addr_out;
  end

  task automatic clear_mon();
    edge_q.delete(); latch_addr_q.delete(); oe_q.delete(); done_q.delete(); acc_q.delete();
    unstable = 0; addr_viol = 0; lit = 0; run = 0;
  endtask

  // ---------------- reference model ----------------
  logic [5:0] model_q[$];

  function automatic logic [2:0] px_bits(input int px, input int p);
    int r, g, b;
    r = px / 64;
    g = (px / 8) % 8;
    b = px % 8;
    return {((r >> p) & 1) != 0, ((g >> p) & 1) != 0, ((b >> p) & 1) != 0};
  endfunction

  // Appends the expected {rgb0,rgb1} at each shift-clock rising edge of one line.
  task automatic add_model(input line_t d);
    for (int p = 0; p < 3; p++)
      for (int c = NUM_COLS - 1; c >= 0; c--)
        model_q.push_back({px_bits(int'(d[0][c]), p), px_bits(int'(d[1][c]), p)});
  endtask

  function automatic int edge_mism();
    int m;
    m = 0;
    if (edge_q.size() != model_q.size()) return 1000 + edge_q.size();
    foreach (edge_q[i]) if (edge_q[i] !== model_q[i]) m++;
    return m;
  endfunction

  function automatic line_t rand_line();
    line_t d;
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < NUM_COLS; c++)
        d[h][c] = 9'($urandom_range(0, 511));
    return d;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic send_line(input line_t d, input logic [4:0] a, output bit ok);
    line_data = d; line_addr = a; tvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tready) begin ok = 1'b1; break; end
      tick(1);
    end
    tick(1);
    tvalid = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b0; tvalid = 1'b0; blank_in = 1'b0;
    tick(3);
    n_checks++; if (tready !== 1'b1) $display("FAIL reset_tready got %b want 1", tready); else n_pass++;
    n_checks++; if (led_oe_n !== 1'b1) $display("FAIL reset_oe_n got %b want 1", led_oe_n); else n_pass++;
    n_checks++; if (addr_out !== 5'd0) $display("FAIL reset_addr got %0d want 0", addr_out); else n_pass++;
    n_checks++;
    if ({rgb0, rgb1, led_clk, led_latch, line_done} !== 9'd0)
      $display("FAIL reset_outs got %b want 0", {rgb0, rgb1, led_clk, led_latch, line_done});
    else n_pass++;
    rst_in = 1'b1;
    clear_mon();
    tick(20);
    n_checks++;
    if (edge_q.size() != 0 || latch_addr_q.size() != 0)
      $display("FAIL idle_quiet got %0d edges %0d latches want 0", edge_q.size(), latch_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_single_timing();
    line_t d;
    bit ok1, ok2;
    int bad;
    for (int c = 0; c < NUM_COLS; c++) begin d[0][c] = 9'b111_000_000; d[1][c] = '0; end
    clear_mon();
    send_line(d, 5'd5, ok1);
    wait_done(1, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL single_timeout got %b%b want 11", ok1, ok2); else n_pass++;
    bad = 0;
    foreach (edge_q[i]) if (edge_q[i] !== 6'b100_000) bad++;
    n_checks++;
    if (edge_q.size() != 12 || bad != 0)
      $display("FAIL single_edges got %0d edges %0d wrong want 12 edges 0 wrong", edge_q.size(), bad);
    else n_pass++;
    n_checks++;
    if (latch_addr_q.size() != 3) $display("FAIL single_latches got %0d want 3", latch_addr_q.size());
    else n_pass++;
    n_checks++;
    if (oe_q.size() != 3 || oe_q[0] != 2 || oe_q[1] != 4 || oe_q[2] != 8)
      $display("FAIL single_oe_windows got %p want 2,4,8", oe_q);
    else n_pass++;
    n_checks++;
    if (latch_addr_q.size() < 1 || latch_addr_q[0] != 5)
      $display("FAIL single_addr_at_latch got %p want 5", latch_addr_q);
    else n_pass++;
    n_checks++;
    if (acc_q.size() != 1 || done_q.size() != 1 || done_q[0] - acc_q[0] != LINE_CYC)
      $display("FAIL single_latency got acc %p done %p want %0d apart", acc_q, done_q, LINE_CYC);
    else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL rgb_setup got %0d unstable want 0", unstable); else n_pass++;
    n_checks++; if (addr_out !== 5'd5) $display("FAIL single_addr_hold got %0d want 5", addr_out); else n_pass++;
  endtask

  task automatic test_bcm_weighting();
    line_t d;
    bit ok1, ok2;
    int mask, m;
    d = '0;
    d[0][3] = 9'b000_101_000;
    clear_mon(); model_q.delete(); add_model(d);
    send_line(d, 5'd9, ok1);
    wait_done(1, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL bcm_timeout got %b%b want 11", ok1, ok2); else n_pass++;
    mask = 0;
    foreach (edge_q[i]) if (edge_q[i][4]) mask |= (1 << i);
    n_checks++;
    if (mask != 32'h101) $display("FAIL bcm_green_edges got %h want 101", mask); else n_pass++;
    m = edge_mism();
    n_checks++; if (m != 0) $display("FAIL bcm_model got %0d mismatches want 0", m); else n_pass++;
  endtask

  task automatic test_back_to_back();
    line_t d1, d2;
    bit ok2;
    int busy_ready, m;
    bit got_done;
    d1 = rand_line(); d2 = rand_line();
    clear_mon(); model_q.delete(); add_model(d1); add_model(d2);
    line_data = d1; line_addr = 5'd31; tvalid = 1'b1;
    tick(1);
    line_data = d2; line_addr = 5'd0;
    busy_ready = 0; got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (line_done) begin got_done = 1'b1; break; end
      if (tready) busy_ready++;
      tick(1);
    end
    tick(1);
    tvalid = 1'b0;
    wait_done(2, ok2);
    n_checks++; if (!(got_done && ok2)) $display("FAIL b2b_timeout got %b%b want 11", got_done, ok2); else n_pass++;
    n_checks++; if (busy_ready != 0) $display("FAIL b2b_tready_busy got %0d want 0", busy_ready); else n_pass++;
    n_checks++;
    if (acc_q.size() != 2 || done_q.size() < 1 || acc_q[1] != done_q[0] + 1)
      $display("FAIL b2b_accept got acc %p done %p want second accept on done cycle", acc_q, done_q);
    else n_pass++;
    n_checks++;
    if (latch_addr_q.size() != 6 || latch_addr_q[0] != 31 || latch_addr_q[3] != 0)
      $display("FAIL b2b_addr got %p want 31x3 then 0x3", latch_addr_q);
    else n_pass++;
    n_checks++; if (addr_viol != 0) $display("FAIL b2b_addr_while_lit got %0d want 0", addr_viol); else n_pass++;
    m = edge_mism();
    n_checks++; if (m != 0) $display("FAIL b2b_model got %0d mismatches want 0", m); else n_pass++;
  endtask

  task automatic test_blank();
    line_t d;
    bit ok1, ok2, seen;
    int nl, m;
    d = rand_line();
    for (int c = 0; c < NUM_COLS; c++) d[0][c] = 9'h1FF;
    clear_mon(); model_q.delete(); add_model(d);
    send_line(d, 5'd17, ok1);
    nl = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (led_latch) nl++;
      if (nl == 3) begin seen = 1'b1; break; end
      tick(1);
    end
    blank_in = 1'b1;
    wait_done(1, ok2);
    blank_in = 1'b0;
    n_checks++; if (!(ok1 && ok2 && seen)) $display("FAIL blank_timeout got %b%b%b want 111", ok1, ok2, seen); else n_pass++;
    n_checks++;
    if (oe_q.size() != 2 || oe_q[0] != 2 || oe_q[1] != 4)
      $display("FAIL blank_windows got %p want 2,4", oe_q);
    else n_pass++;
    n_checks++; if (lit != 6) $display("FAIL blank_lit got %0d want 6", lit); else n_pass++;
    n_checks++;
    if (acc_q.size() != 1 || done_q.size() != 1 || done_q[0] - acc_q[0] != LINE_CYC)
      $display("FAIL blank_latency got acc %p done %p want %0d apart", acc_q, done_q, LINE_CYC);
    else n_pass++;
    m = edge_mism();
    n_checks++; if (m != 0) $display("FAIL blank_model got %0d mismatches want 0", m); else n_pass++;
  endtask

  task automatic test_reset_mid();
    line_t d;
    bit ok1, ok2, seen;
    int nl, m;
    logic [4:0] a;
    d = rand_line();
    clear_mon();
    send_line(d, 5'd12, ok1);
    nl = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (led_latch) nl++;
      if (nl == 2) begin seen = 1'b1; break; end
      tick(1);
    end
    tick(1);
    n_checks++; if (!(ok1 && seen && led_oe_n == 1'b0)) $display("FAIL rstmid_setup got %b%b oe %b want 11 oe 0", ok1, seen, led_oe_n); else n_pass++;
    rst_in = 1'b0;
    tick(1);
    n_checks++;
    if ({led_oe_n, tready, addr_out} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL rstmid_state got oe %b rdy %b addr %0d want 1 1 0", led_oe_n, tready, addr_out);
    else n_pass++;
    rst_in = 1'b1;
    clear_mon();
    tick(60);
    n_checks++;
    if (done_q.size() != 0 || edge_q.size() != 0)
      $display("FAIL rstmid_discard got %0d done %0d edges want 0", done_q.size(), edge_q.size());
    else n_pass++;
    d = rand_line(); a = 5'($urandom_range(0, 31));
    clear_mon(); model_q.delete(); add_model(d);
    send_line(d, a, ok1);
    wait_done(1, ok2);
    m = edge_mism();
    n_checks++;
    if (!(ok1 && ok2) || m != 0 || oe_q.size() != 3 || oe_q[0] != 2)
      $display("FAIL rstmid_restart got ok %b%b mism %0d oe %p want plane0 first", ok1, ok2, m, oe_q);
    else n_pass++;
  endtask

  task automatic test_random();
    line_t d;
    bit ok1, ok2;
    int m;
    logic [4:0] a;
    for (int k = 0; k < 4; k++) begin
      d = rand_line();
      a = (k == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      clear_mon(); model_q.delete(); add_model(d);
      tick($urandom_range(0, 3));
      send_line(d, a, ok1);
      wait_done(1, ok2);
      m = edge_mism();
      n_checks++; if (!(ok1 && ok2) || m != 0) $display("FAIL rand%0d_edges got ok %b%b mism %0d want 0", k, ok1, ok2, m); else n_pass++;
      n_checks++;
      if (oe_q.size() != 3 || oe_q[0] != 2 || oe_q[1] != 4 || oe_q[2] != 8)
        $display("FAIL rand%0d_oe got %p want 2,4,8", k, oe_q);
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 1 || done_q.size() != 1 || done_q[0] - acc_q[0] != LINE_CYC)
        $display("FAIL rand%0d_latency got acc %p done %p want %0d apart", k, acc_q, done_q, LINE_CYC);
      else n_pass++;
      n_checks++; if (addr_out !== a) $display("FAIL rand%0d_addr got %0d want %0d", k, addr_out, a); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_timing();
    test_bcm_weighting();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hub75_bcm_scan_driver.md
Name: hub75_bcm_scan_driver

Overview:
- Parametrised next-generation HUB75 line driver.
- Accepts one scan line pair per valid/ready handshake: an upper-half row and a lower-half row, plus the row address.
- Displays that line pair with binary-code-modulation (BCM) colour depth: one shift/latch/display pass per colour bit plane, each plane lit twice as long as the previous one.
- Owns the panel row address and blanking, so the address changes only while the LEDs are dark. Sits between frame_manager and the HUB75 connector pins.

Parameters:
- NUM_COLS, 64, pixels shifted per row.
- SCAN_RATE, 32, row-pair addresses; address width is $clog2(SCAN_RATE).
- RGB_RES, 9, bits per pixel. Packed {R,G,B}, R in the MSBs. CH_BITS = RGB_RES/3 bits per channel. RGB_RES must be a multiple of 3.
- BASE_OE_CYCLES, 4, lit cycles for bit plane 0. Plane b is lit for BASE_OE_CYCLES<<b cycles.

Ports:
- clk_in  input  1  system clock; only clock.
- rst_in  input  1  synchronous, active-low reset.
- line_data  input  [1:0][NUM_COLS-1:0][RGB_RES-1:0]  index [0] is the upper-half row, [1] is the lower-half row.
- line_addr  input  $clog2(SCAN_RATE)  row-pair address for line_data.
- tvalid  input  1  line_data and line_addr are valid.
- tready  output  1  block can accept a line.
- blank_in  input  1  force LEDs dark; timing is unaffected.
- rgb0  output  3  upper-half {R,G,B} bits.
- rgb1  output  3  lower-half {R,G,B} bits.
- led_clk  output  1  HUB75 shift clock.
- led_latch  output  1  HUB75 latch.
- led_oe_n  output  1  HUB75 output enable, active-low (0 = lit).
- addr_out  output  $clog2(SCAN_RATE)  panel row address.
- line_done  output  1  one-cycle pulse when a line finishes.

Behaviour:
- Reset (rst_in==0 at a clk_in edge):
  - Next state IDLE.
  - tready=1, rgb0=rgb1=0, led_clk=0, led_latch=0, led_oe_n=1, addr_out=0, line_done=0.
  - Plane, pixel and display counters clear. Any captured line is discarded, including mid-shift or mid-display.
- States are IDLE, SHIFT, LATCH and DISPLAY.
- IDLE:
  - tready=1, led_oe_n=1.
  - On tvalid&&tready, register line_data and line_addr. Set plane=0, pix=NUM_COLS-1, and go to SHIFT.
  - tready drops on the following cycle.
  - tvalid while busy is ignored; the source holds until tready returns.
- SHIFT (two cycles per pixel):
  - Phase 0: rgb0 = {R[plane],G[plane],B[plane]} of upper-half pixel pix, rgb1 likewise for the lower half, led_clk=0.
  - Phase 1: rgb0/rgb1 are held and led_clk=1.
  - After phase 1 with pix==0, go to LATCH. Otherwise decrement pix and return to phase 0.
  - Pixel NUM_COLS-1 is shifted first.
  - Registered outputs: rgb values are stable one full cycle before the led_clk rising edge.
- LATCH (1 cycle):
  - led_latch=1, led_clk=0, led_oe_n=1.
  - If plane==0, addr_out takes the captured address here. addr_out is otherwise held, so it never changes while led_oe_n==0.
  - Next state is DISPLAY, with the counter loaded to BASE_OE_CYCLES<<plane.
- DISPLAY:
  - led_oe_n = blank_in for exactly BASE_OE_CYCLES<<plane cycles. blank_in does not stretch or shorten the window.
  - On the last cycle:
    - If plane==CH_BITS-1: go to IDLE and pulse line_done=1 on the IDLE-entry cycle.
    - Else: plane+1, pix=NUM_COLS-1, go to SHIFT.
  - led_oe_n returns to 1 on the cycle DISPLAY exits.
- Cycle counts:
  - Line occupancy from the accept cycle to the line_done cycle is L = CH_BITS*(2*NUM_COLS+1) + BASE_OE_CYCLES*(2^CH_BITS-1).
  - Back-to-back lines are accepted in the line_done cycle, so throughput is one line per L+1 cycles.
- Boundaries:
  - line_addr==SCAN_RATE-1 passes straight through; there is no internal address increment or wrap.
  - BASE_OE_CYCLES<<(CH_BITS-1) must fit the display counter. Size it as $clog2(BASE_OE_CYCLES<<CH_BITS).
  - Pixel value 0 never lights. Pixel all-ones is lit for BASE_OE_CYCLES*(2^CH_BITS-1) cycles.

Test Plan:
All scenarios use NUM_COLS=4, SCAN_RATE=32, RGB_RES=9, BASE_OE_CYCLES=2, so L = 3*9 + 2*7 = 41.
- Reset/idle:
  - Stimulus: hold rst_in=0 for 3 cycles, then release.
  - Required: tready=1, led_oe_n=1, addr_out=0, all other outputs 0.
  - Then tvalid=0 for 20 cycles → no led_clk edges.
- Single line, timing:
  - Stimulus: addr=5, all upper pixels R=7 (9'b111_000_000), lower pixels 0.
  - Required: 4 led_clk rising edges per plane, rgb0=3'b100 and rgb1=3'b000 at each edge.
  - Required: led_latch pulses 3 times; led_oe_n low windows of 2, 4 and 8 cycles.
  - Required: addr_out=5 from the first latch; line_done exactly 41 cycles after accept.
- BCM weighting:
  - Stimulus: upper pixel 3 G=5 (9'b000_101_000), all others 0.
  - Required: rgb0[1]=1 on the first edge of planes 0 and 2 only (pixel 3 is shifted first).
- Back-to-back with tvalid held:
  - Stimulus: hold tvalid with addr 31 then addr 0.
  - Required: second accept on the line_done cycle.
  - Required: addr_out changes 31→0 only while led_oe_n=1; tready=0 throughout the first line.
- blank_in:
  - Stimulus: blank_in=1 during plane 2.
  - Required: led_oe_n stays 1 for those 8 cycles; line_done still at cycle 41.
- Reset mid-operation:
  - Stimulus: rst_in=0 during plane 1 DISPLAY.
  - Required: next edge gives led_oe_n=1, addr_out=0, tready=1.
  - Required: no line_done; the next accepted line starts at plane 0.
